// File: rtl/fp_sqrt_preproc.sv
// Square-root front end: classifies a binary32 operand, resolves special cases,
// and prepares the 2.24 radicand and halved exponent for the root array.
module fp_sqrt_preproc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] out_radicand,
  output logic [7:0]  out_exp,
  output logic        out_sign,
  output logic        out_special,
  output logic [31:0] out_result,
  output logic        out_invalid,
  output logic        busy
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_PINF,
    CLS_QNAN,
    CLS_INVALID
  } opClass_t;

  // Handshake: a transfer happens on a side only when valid and ready are
  // both 1 in the same cycle; a stage loads when empty or when it drains.
  logic       s1Valid;
  logic       s1Sign;
  logic [7:0] s1Exp;
  logic [22:0] s1Frac;
  opClass_t   s1Class;
  opClass_t   inClass;
  logic       s2Load;

  logic [8:0]  expSum;
  logic [7:0]  nextExp;
  logic [25:0] nextRadicand;
  logic [31:0] nextResult;
  logic        nextSpecial;
  logic        nextInvalid;
  logic        nextSign;

  // Zero/denormal flush takes priority so that negative denormals give -0.
  always_comb begin
    inClass = CLS_NORMAL;
    if (in_data[30:23] == 8'd0)
      inClass = CLS_ZERO;
    else if (in_data[30:23] == 8'hFF && in_data[22:0] != 23'd0)
      inClass = in_data[22] ? CLS_QNAN : CLS_INVALID;
    else if (in_data[31])
      inClass = CLS_INVALID;
    else if (in_data[30:23] == 8'hFF)
      inClass = CLS_PINF;
  end

  always_comb begin
    s2Load   = !out_valid || out_ready;
    in_ready = !s1Valid || s2Load;
    busy     = s1Valid || out_valid;
  end

  // An odd biased exponent means an even unbiased one, so the significand
  // keeps its weight; otherwise it is doubled to make the exponent even.
  always_comb begin
    expSum       = {1'b0, s1Exp} + 9'd127;
    nextExp      = 8'd0;
    nextRadicand = 26'd0;
    nextResult   = 32'd0;
    nextSpecial  = 1'b1;
    nextInvalid  = 1'b0;
    nextSign     = 1'b0;
    case (s1Class)
      CLS_NORMAL: begin
        nextSpecial  = 1'b0;
        nextExp      = expSum[8:1];
        nextRadicand = s1Exp[0] ? {1'b0, 1'b1, s1Frac, 1'b0} : {1'b1, s1Frac, 2'b00};
      end
      CLS_ZERO: begin
        nextResult = {s1Sign, 31'd0};
        nextSign   = s1Sign;
      end
      CLS_PINF:    nextResult = PINF;
      CLS_QNAN:    nextResult = QNAN;
      CLS_INVALID: begin
        nextResult  = QNAN;
        nextInvalid = 1'b1;
      end
      default: nextResult = QNAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid      <= 1'b0;
      s1Sign       <= 1'b0;
      s1Exp        <= 8'd0;
      s1Frac       <= 23'd0;
      s1Class      <= CLS_NORMAL;
      out_valid    <= 1'b0;
      out_radicand <= 26'd0;
      out_exp      <= 8'd0;
      out_sign     <= 1'b0;
      out_special  <= 1'b0;
      out_result   <= 32'd0;
      out_invalid  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1Valid <= in_valid;
        if (in_valid) begin
          s1Sign  <= in_data[31];
          s1Exp   <= in_data[30:23];
          s1Frac  <= in_data[22:0];
          s1Class <= inClass;
        end
      end
      if (s2Load) begin
        out_valid <= s1Valid;
        if (s1Valid) begin
          out_radicand <= nextRadicand;
          out_exp      <= nextExp;
          out_sign     <= nextSign;
          out_special  <= nextSpecial;
          out_result   <= nextResult;
          out_invalid  <= nextInvalid;
        end
      end
    end
  end

endmodule

// File: doc/fp_sqrt_preproc.md
FP_SQRT_PREPROC -- requirements
Module: fp_sqrt_preproc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  in_data holds an operand.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  32  IEEE-754 binary32 operand.
REQ-007 out_valid  output  1  output fields hold a result.
REQ-008 out_ready  input  1  downstream root array consumes this cycle.
REQ-009 out_radicand  output  26  radicand for the root array, format 2.24 unsigned.
REQ-010 out_exp  output  8  biased exponent of the result.
REQ-011 out_sign  output  1  result sign, 0 for all non-special results.
REQ-012 out_special  output  1  out_result is final; downstream bypasses the root array.
REQ-013 out_result  output  32  final binary32 result when out_special=1, else 0.
REQ-014 out_invalid  output  1  IEEE invalid-operation flag.
REQ-015 busy  output  1  at least one pipeline stage is valid.

Function
REQ-016 The block SHALL be a 2-stage pipeline (S1 classify/register, S2 compute/register) with latency 2 cycles when not stalled and throughput 1 operand per cycle.
REQ-017 A transfer SHALL occur on each side only when valid and ready are both 1 in the same cycle.
REQ-018 Each stage SHALL advance when it is empty or the stage after it advances; in_ready = !S1.valid | S1 advancing (combinational from out_ready, no bubble).
REQ-019 out_valid and all out_* fields SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 Fields: s=in_data[31], E=in_data[30:23], f=in_data[22:0]; significand S={1,f} (24 bits).
REQ-021 Normal positive operand (s=0, 1<=E<=254): out_special=0, out_exp=(E+127)>>1 computed at 9-bit width.
REQ-022 If E is odd (unbiased exponent even), out_radicand SHALL be {1'b0,S,1'b0}; if E is even, {S,2'b00}.
REQ-023 +Inf (0x7F800000): out_special=1, out_result=0x7F800000, out_invalid=0.
REQ-024 ±0 and all denormals (E=0) SHALL flush to zero: out_result={s,31'b0}, out_special=1, out_invalid=0.
REQ-025 Quiet NaN (E=255, f[22]=1): out_result=0x7FC00000, out_special=1, out_invalid=0.
REQ-026 Signalling NaN (E=255, f!=0, f[22]=0): out_result=0x7FC00000, out_special=1, out_invalid=1.
REQ-027 Negative non-zero, non-NaN operand (including -Inf and negative normals): out_result=0x7FC00000, out_special=1, out_invalid=1.
REQ-028 When out_special=1, out_radicand and out_exp SHALL be 0.
REQ-029 When out_special=0, out_result and out_invalid SHALL be 0.
REQ-030 Operands SHALL exit in acceptance order, with no drop or duplication under any out_ready pattern.
REQ-031 busy SHALL be the OR of the S1 and S2 valid bits.

Reset
REQ-032 While rst=1 at a clock edge, both valid bits SHALL clear and all out_* data fields SHALL become 0; in_ready SHALL read 1 from the first cycle after reset.
REQ-033 Operands in flight when rst asserts SHALL be discarded without producing an output; in_valid is ignored in cycles with rst=1.

Verification
REQ-034 Accept 0x40800000 (4.0) at cycle t with out_ready=1 -> at t+2: out_valid=1, out_radicand=0x1000000, out_exp=128, out_special=0.
REQ-035 Accept 0x40000000 (2.0) -> out_radicand=0x2000000, out_exp=127, out_special=0.
REQ-036 Back-to-back inputs 0xBF800000, 0x7F800001, 0x7FC00000, 0x80000000, 0x00000001 -> results {0x7FC00000,inv=1}, {0x7FC00000,inv=1}, {0x7FC00000,inv=0}, {0x80000000,inv=0}, {0x00000000,inv=0}, all with out_special=1.
REQ-037 Hold out_ready=0 and offer 3 operands back-to-back -> first 2 accepted, in_ready=0 on the 3rd, busy=1; then raise out_ready -> 3 results in order with outputs stable while stalled.
REQ-038 Assert rst for 1 cycle with both stages full -> out_valid=0 and busy=0 next cycle, no stale result emitted; a new operand accepted afterwards has latency 2.
REQ-039 Apply random out_ready toggling over 10k random operands -> scoreboard against a reference model, exact match, order preserved.
